// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank.
// FSM state encodings and the frame-width helper live here.
// Imported by spi_reg_bank; carries no logic of its own.
package spi_reg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HDR  = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Total frame length: RW bit, address field, data field.
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between a controller (master) and the register bank (slave).
// Combinational wires only; no latency of its own.
// No backpressure: SPI is fully controller-paced.
interface spi_reg_bank_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall pulses.
// Latency: SYNC_LEN clk to sync_o; rise_o/fall_o are combinational off sync_o.
// No backpressure; pulses are one clk wide.
module spi_sync_edge #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_LEN-1:0] sync_q;
  logic                prev_q;

  // Shift the pin through the synchroniser chain and keep the previous level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_LEN-2:0], async_i};
      prev_q <= sync_q[SYNC_LEN-1];
    end
  end

  assign sync_o = sync_q[SYNC_LEN-1];
  assign rise_o = sync_q[SYNC_LEN-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_LEN-1] & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral driving NUM_REGS x DATA_W config registers, with read-back, err and wr_stb.
// Latency: ~SYNC_LEN+1 clk pin-to-action; commit/wr_stb/err one clk after synchronised ncs rise.
// No backpressure (controller-paced). Optional burst mode: define SPI_BURST_EN.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 5,
  parameter int SYNC_LEN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic                       err
);

  localparam int CNT_W = $clog2(frame_w(ADDR_W, DATA_W)) + 1;

  logic sclk_rise, sclk_fall, sclk_lvl;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_rise, ncs_fall, ncs_lvl;

  spi_sync_edge #(.SYNC_LEN(SYNC_LEN)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_i(spi.sclk), .sync_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.SYNC_LEN(SYNC_LEN)) u_sync_copi (
    .clk(clk), .rst(rst), .async_i(spi.copi), .sync_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall));
  spi_sync_edge #(.SYNC_LEN(SYNC_LEN)) u_sync_ncs (
    .clk(clk), .rst(rst), .async_i(spi.ncs), .sync_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall));

  // Only edges of sclk/ncs and the level of copi matter.
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall, ncs_lvl};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ovr_q, ovr_d;    // overrun, or (burst) a word landed past the last register
  logic [DATA_W-2:0]   rd_sr_q, rd_sr_d; // read bits still to be shown after the one on cipo
  logic                cipo_q, cipo_d;
  logic                oe_q, oe_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] stb_q, stb_d;
  logic                err_q, err_d;
`ifdef SPI_BURST_EN
  logic                word_q, word_d;  // at least one full word seen in this burst
`endif

  logic [ADDR_W:0]     hdr_new;
  logic [DATA_W-1:0]   dat_new;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_word;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // Read mux: register at rd_addr, zero for unimplemented addresses.
  always_comb begin
    hdr_new = {hdr_q, copi_s};
    dat_new = {dat_q[DATA_W-2:0], copi_s};
`ifdef SPI_BURST_EN
    rd_addr = (state_q == ST_HDR) ? hdr_new[ADDR_W-1:0] : addr_q + 1'b1;
`else
    rd_addr = hdr_new[ADDR_W-1:0];
`endif
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(rd_addr) == k) rd_word = regs_q[k];
    end
  end

  // Frame FSM: ncs rise has priority over ncs fall, which has priority over sclk edges.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    hdr_d     = hdr_q;
    dat_d     = dat_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    ovr_d     = ovr_q;
    rd_sr_d   = rd_sr_q;
    cipo_d    = cipo_q;
    oe_d      = oe_q;
    regs_d    = regs_q;
    stb_d     = '0;
    err_d     = 1'b0;
`ifdef SPI_BURST_EN
    word_d    = word_q;
`endif
    if (ncs_rise) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      cipo_d  = 1'b0;
      case (state_q)
        ST_HDR: err_d = 1'b1;
`ifdef SPI_BURST_EN
        // Words already committed as they completed; only judge the frame here.
        ST_DATA: err_d = (bit_cnt_q != '0) || !word_q || ovr_q;
`else
        ST_DATA: err_d = 1'b1;
        ST_DONE: begin
          if (ovr_q || !addr_ok(addr_q)) begin
            err_d = 1'b1;
          end else if (rw_q) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (int'(addr_q) == k) begin
                regs_d[k] = dat_q;
                stb_d[k]  = 1'b1;
              end
            end
          end
        end
`endif
        default: ;
      endcase
    end else if (ncs_fall) begin
      // Start of frame, or a glitch mid-frame: restart the header either way.
      state_d   = ST_HDR;
      bit_cnt_d = '0;
      hdr_d     = '0;
      dat_d     = '0;
      ovr_d     = 1'b0;
      oe_d      = 1'b0;
      cipo_d    = 1'b0;
`ifdef SPI_BURST_EN
      word_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_HDR: begin
          if (sclk_rise) begin
            hdr_d     = hdr_new[ADDR_W-1:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(ADDR_W)) begin
              rw_d      = hdr_new[ADDR_W];
              addr_d    = hdr_new[ADDR_W-1:0];
              bit_cnt_d = '0;
              state_d   = ST_DATA;
              if (!hdr_new[ADDR_W] && addr_ok(hdr_new[ADDR_W-1:0])) begin
                rd_sr_d = rd_word[DATA_W-2:0];
                cipo_d  = rd_word[DATA_W-1];
                oe_d    = 1'b1;
              end
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            dat_d     = dat_new;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SPI_BURST_EN
              bit_cnt_d = '0;
              word_d    = 1'b1;
              addr_d    = addr_q + 1'b1;
              if (addr_ok(addr_q) && !ovr_q) begin
                if (rw_q) begin
                  for (int k = 0; k < NUM_REGS; k++) begin
                    if (int'(addr_q) == k) begin
                      regs_d[k] = dat_new;
                      stb_d[k]  = 1'b1;
                    end
                  end
                end
              end else begin
                ovr_d = 1'b1;
              end
              if (!rw_q) begin
                rd_sr_d = ovr_d ? '0 : rd_word[DATA_W-2:0];
                cipo_d  = oe_q & ~ovr_d & rd_word[DATA_W-1];
              end
`else
              state_d = ST_DONE;
`endif
            end
          end else if (sclk_fall && oe_q && bit_cnt_q != '0) begin
            // The fall right after a (re)load must not shift: the MSB is still unsampled.
            cipo_d  = rd_sr_q[DATA_W-2];
            rd_sr_d = rd_sr_q << 1;
          end
        end
        ST_DONE: begin
          if (sclk_rise) ovr_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      hdr_q     <= '0;
      dat_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      ovr_q     <= 1'b0;
      rd_sr_q   <= '0;
      cipo_q    <= 1'b0;
      oe_q      <= 1'b0;
      stb_q     <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
`ifdef SPI_BURST_EN
      word_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      hdr_q     <= hdr_d;
      dat_q     <= dat_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      ovr_q     <= ovr_d;
      rd_sr_q   <= rd_sr_d;
      cipo_q    <= cipo_d;
      oe_q      <= oe_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
`ifdef SPI_BURST_EN
      word_q    <= word_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_stb      = stb_q;
  assign err         = err_q;
  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = oe_q;

endmodule
